// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared constants and types for the L2 cache slice.
//   BLOCK_W : width of one cache block / memory transfer (128 bits)
//   ADDR_W  : block address width, byte address bits [31:4] (28 bits)
//   state_t : controller states IDLE / WRITEBACK / ALLOCATE
package l2_cache_pkg;
  localparam int BLOCK_W = 128;
  localparam int ADDR_W  = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;
endpackage

// File: rtl/l2_cache_array.sv
// l2_cache_array: per-line valid/dirty/tag/data storage.
//   clk, rst_n  : clock, asynchronous active-low reset (clears valid/dirty)
//   idx         : line index for both the asynchronous read and the write
//   line_*      : asynchronous read of the indexed line
//   fill_en     : install fill_tag/fill_data, set valid, dirty=fill_dirty
//   clean_en    : clear the dirty bit of the indexed line
module l2_cache_array
  import l2_cache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   idx,
  output logic               line_valid,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLOCK_W-1:0] line_data,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_data,
  input  logic               fill_dirty,
  input  logic               clean_en
);
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_mem [NUM_LINES];

  // Status bits live in flops so reset can clear every line at once.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_status
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
        dirty_reg[gi] <= 1'b0;
      end else if (idx == IDX_W'(gi)) begin
        if (fill_en) begin
          valid_reg[gi] <= 1'b1;
          dirty_reg[gi] <= fill_dirty;
        end else if (clean_en) begin
          dirty_reg[gi] <= 1'b0;
        end
      end
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_data;
    end
  end

  assign line_valid = valid_reg[idx];
  assign line_dirty = dirty_reg[idx];
  assign line_tag   = tag_mem[idx];
  assign line_data  = data_mem[idx];
endmodule

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped, write-back, write-allocate L2 cache of 128-bit blocks.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   proc_read/proc_write/proc_addr  : L1 block request, held until proc_ready
//   proc_wdata / proc_rdata         : L1 write block / read block
//   proc_ready                      : request completes this cycle (IDLE only)
//   mem_read/mem_write/mem_addr     : registered memory request, held to mem_ready
//   mem_wdata / mem_rdata           : victim block out / fill block in
//   mem_ready                       : memory transaction completes this cycle
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [BLOCK_W-1:0] proc_wdata,
  output logic [BLOCK_W-1:0] proc_rdata,
  output logic               proc_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_t              state_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic                req_write_reg;

  logic                idle;
  logic [ADDR_W-1:0]   cur_addr;
  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                hit, victim_dirty;
  logic                fill_en, clean_en;

  assign idle = (state_reg == IDLE);

  // proc_addr may wander while a miss is outstanding, so the latched copy
  // addresses the array outside IDLE.
  assign cur_addr = idle ? proc_addr : req_addr_reg;
  assign cur_idx  = cur_addr[IDX_W-1:0];
  assign cur_tag  = cur_addr[ADDR_W-1:IDX_W];

  assign hit          = line_valid && (line_tag == cur_tag);
  assign victim_dirty = line_valid && line_dirty;

  // A write (or read+write) finishes at once unless it must evict dirty data.
  assign proc_ready = idle && (proc_write ? (hit || !victim_dirty)
                                          : (proc_read && hit));
  assign proc_rdata = line_data;

  assign fill_en  = (idle && proc_write && proc_ready) ||
                    (state_reg == ALLOCATE && mem_ready);
  assign clean_en = (state_reg == WRITEBACK) && mem_ready;

  l2_cache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (cur_idx),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .fill_en    (fill_en),
    .fill_tag   (cur_tag),
    .fill_data  (idle ? proc_wdata : mem_rdata),
    .fill_dirty (idle),
    .clean_en   (clean_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      req_addr_reg  <= '0;
      req_write_reg <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if ((proc_read || proc_write) && !proc_ready) begin
            req_addr_reg  <= proc_addr;
            req_write_reg <= proc_write;
            if (victim_dirty) begin
              state_reg <= WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {line_tag, cur_idx};
              mem_wdata <= line_data;
            end else begin
              state_reg <= ALLOCATE;
              mem_read  <= 1'b1;
              mem_addr  <= proc_addr;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            // A write needs no fill: the line is now clean, so the held
            // request completes as a clean miss back in IDLE.
            if (req_write_reg) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= ALLOCATE;
              mem_read  <= 1'b1;
              mem_addr  <= req_addr_reg;
            end
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache.sv
module tb_l2_cache;
  typedef struct {
    logic         is_write;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_txn_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0, proc_write = 1'b0;
  logic [27:0]  proc_addr = '0;
  logic [127:0] proc_wdata = '0;
  logic [127:0] proc_rdata;
  logic         proc_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int chk_cnt = 0;
  int fail_cnt = 0;
  int mem_lat = 3;
  int both_high_cnt = 0;
  int txn_no = 0;
  bit check_mem = 1'b1;

  logic [127:0] sb_q[$];        // expected proc_rdata per read
  mem_txn_t     mem_exp_q[$];   // expected memory transactions
  logic [127:0] mem_store[logic [27:0]];
  logic [127:0] ref_mem[logic [27:0]];

  l2_cache #(.NUM_LINES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_ready(proc_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] init_data(input logic [27:0] a);
    if (a == 28'h0000010) return {16{8'hA5}};
    return {4{4'hD, a}};
  endfunction

  function automatic logic [127:0] ref_read(input logic [27:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_data(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic w, input logic [27:0] a, input logic [127:0] d);
    mem_txn_t t;
    t.is_write = w; t.addr = a; t.data = d;
    mem_exp_q.push_back(t);
  endtask

  // Issue one request, hold it until proc_ready, check the wait-cycle count.
  task automatic do_req(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, input int exp_wait);
    int waits;
    @(posedge clk); #1;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
    if (rd && !wr) sb_q.push_back(ref_read(a));
    else ref_mem[a] = d;
    waits = 0;
    forever begin
      @(negedge clk);
      if (proc_ready) break;
      waits++;
      if (waits > 60) begin
        chk_cnt++; fail_cnt++;
        $display("FAIL req_timeout: addr %h got no proc_ready within 60 cycles", a);
        break;
      end
    end
    txn_no++;
    $display("txn %0d %s addr=%h waits=%0d", txn_no, wr ? "WR" : "RD", a, waits);
    if (exp_wait >= 0) check("wait_cycles", 128'(waits), 128'(exp_wait));
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  // Monitor: compare read data whenever the DUT completes a read.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (proc_ready && proc_read && !proc_write) begin
        if (sb_q.size() == 0) begin
          chk_cnt++; fail_cnt++;
          $display("FAIL rdata_unexpected: got %h with nothing expected", proc_rdata);
        end else begin
          e = sb_q.pop_front();
          check("rdata", proc_rdata, e);
        end
      end
    end
  end

  // Memory model with mem_lat cycles of request before mem_ready.
  initial begin
    int cnt;
    mem_txn_t t;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_high_cnt++;
      if (!rst_n) begin
        cnt = 0; mem_ready = 1'b0;
      end else begin
        if (mem_ready) mem_ready = 1'b0;
        if (mem_read || mem_write) begin
          cnt++;
          if (cnt >= mem_lat) begin
            cnt = 0;
            mem_ready = 1'b1;
            if (mem_read)
              mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_data(mem_addr);
            else
              mem_store[mem_addr] = mem_wdata;
            $display("mem %s addr=%h data=%h", mem_write ? "WR" : "RD", mem_addr,
                     mem_write ? mem_wdata : mem_rdata);
            if (check_mem) begin
              if (mem_exp_q.size() == 0) begin
                chk_cnt++; fail_cnt++;
                $display("FAIL mem_unexpected: got %s addr %h, none required",
                         mem_write ? "write" : "read", mem_addr);
              end else begin
                t = mem_exp_q.pop_front();
                check("mem_kind", 128'(mem_write), 128'(t.is_write));
                check("mem_addr", 128'(mem_addr), 128'(t.addr));
                if (t.is_write) check("mem_wdata", mem_wdata, t.data);
              end
            end
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  initial begin
    logic [27:0]  a;
    logic [127:0] d;
    logic         w;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_proc_ready", 128'(proc_ready), 128'(0));
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_mem_write", 128'(mem_write), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    rst_n = 1'b1;

    // Clean read miss, then hit
    exp_mem(1'b0, 28'h0000010, '0);
    do_req(1'b1, 1'b0, 28'h0000010, '0, 4);
    do_req(1'b1, 1'b0, 28'h0000010, '0, 0);
    // Write hit, read back
    do_req(1'b0, 1'b1, 28'h0000010, 128'h1234, 0);
    do_req(1'b1, 1'b0, 28'h0000010, '0, 0);
    // Conflict read with dirty victim
    exp_mem(1'b1, 28'h0000010, 128'h1234);
    exp_mem(1'b0, 28'h0000050, '0);
    do_req(1'b1, 1'b0, 28'h0000050, '0, 7);
    // Write miss to empty line, then conflicting read
    do_req(1'b0, 1'b1, 28'h0000021, 128'hBEEF, 0);
    exp_mem(1'b1, 28'h0000021, 128'hBEEF);
    exp_mem(1'b0, 28'h0000061, '0);
    do_req(1'b1, 1'b0, 28'h0000061, '0, 7);
    do_req(1'b1, 1'b0, 28'h0000050, '0, 0);
    // Read+write together acts as a write miss over a clean line
    do_req(1'b1, 1'b1, 28'h0000021, 128'h5555, 0);
    // Write miss over dirty victim: writeback only, then served in IDLE
    exp_mem(1'b1, 28'h0000021, 128'h5555);
    do_req(1'b0, 1'b1, 28'h0000061, 128'hCAFE, 4);
    do_req(1'b1, 1'b0, 28'h0000061, '0, 0);
    exp_mem(1'b1, 28'h0000061, 128'hCAFE);
    exp_mem(1'b0, 28'h0000021, '0);
    do_req(1'b1, 1'b0, 28'h0000021, '0, 7);

    // Reset in the middle of ALLOCATE
    mem_lat = 10;
    @(posedge clk); #1;
    proc_read = 1'b1; proc_addr = 28'h0000030;
    repeat (3) @(negedge clk);
    check("alloc_mem_read", 128'(mem_read), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_read", 128'(mem_read), 128'(0));
    check("abort_proc_ready", 128'(proc_ready), 128'(0));
    @(negedge clk); proc_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mem_exp_q.delete();
    mem_lat = 3;
    exp_mem(1'b0, 28'h0000050, '0);
    do_req(1'b1, 1'b0, 28'h0000050, '0, 4);
    check("mem_exp_drained", 128'(mem_exp_q.size()), 128'(0));

    // Random sweep against the reference model
    check_mem = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a = (28'($urandom_range(0, 3)) << 6) | 28'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      do_req(!w, w, a, d, -1);
    end
    repeat (2) @(negedge clk);
    check("sb_drained", 128'(sb_q.size()), 128'(0));
    check("mem_rw_exclusive", 128'(both_high_cnt), 128'(0));

    $display("%0d/%0d checks passed", chk_cnt - fail_cnt, chk_cnt);
    $finish;
  end
endmodule
